// File: rtl/mult_pkg.sv
// mult_pkg -- shared definitions for the shift-and-add multiplier.
//   W_DEF   : default operand width in bits.
//   state_t : control FSM encoding (IDLE, RUN, DONE).
package mult_pkg;

  localparam int W_DEF = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage : mult_pkg

// File: rtl/add_w.sv
// add_w -- W-bit ripple-carry adder used by the multiplier datapath.
// Ports:
//   x, y : W-bit addends
//   cin  : carry in
//   s    : W-bit sum
//   cout : carry out of the top bit
module add_w
  import mult_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  input  logic         cin,
  output logic [W-1:0] s,
  output logic         cout
);

  // w_c[k] is the carry into bit k; w_c[W] leaves the adder.
  logic [W:0] w_c;

  assign w_c[0] = cin;

  generate
    for (genvar gi = 0; gi < W; gi++) begin : g_fa
      assign s[gi]      = x[gi] ^ y[gi] ^ w_c[gi];
      assign w_c[gi+1]  = (x[gi] & y[gi]) | (x[gi] & w_c[gi]) | (y[gi] & w_c[gi]);
    end
  endgenerate

  assign cout = w_c[W];

endmodule : add_w

// File: rtl/shift_add_mult.sv
// shift_add_mult -- sequential unsigned shift-and-add multiplier.
// One partial-product step per clock; the result appears W+1 clocks after
// the edge that accepts start, regardless of operand values.
// Ports:
//   clk   : clock, rising edge
//   rst   : synchronous active-high reset
//   start : begin a multiply (only looked at in IDLE)
//   a, b  : W-bit unsigned multiplicand / multiplier, captured at start
//   busy  : high while a multiply is in progress (RUN or DONE)
//   done  : one-cycle pulse, p is valid
//   p     : 2W-bit product, held until the next product is ready
//   ovf   : (only when MULT_OVF_EN is defined) upper half of p nonzero
// Build option: define MULT_OVF_EN to add the ovf port and its register.
// W must be at least 2.
module shift_add_mult
  import mult_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic           busy,
  output logic           done,
  output logic [2*W-1:0] p
`ifdef MULT_OVF_EN
  ,
  output logic           ovf
`endif
);

  localparam int CNT_W = $clog2(W + 1);

  state_t           r_state;
  state_t           w_state_next;
  logic [W-1:0]     r_m;
  logic [W-1:0]     r_q;
  logic [W-1:0]     r_h;
  logic [CNT_W-1:0] r_cnt;
  logic [2*W-1:0]   r_p;

  logic [W-1:0]     w_addend;
  logic [W-1:0]     w_sum;
  logic             w_carry;
  logic [2*W-1:0]   w_hq_next;
  logic             w_last;

  // Partial product: add M into the high half when the current multiplier
  // LSB is set.
  assign w_addend = r_q[0] ? r_m : '0;

  add_w #(.W(W)) u_add (
    .x    (r_h),
    .y    (w_addend),
    .cin  (1'b0),
    .s    (w_sum),
    .cout (w_carry)
  );

  // The carry-out shifts straight into the MSB of H, so no separate carry
  // register is needed and no product bit is dropped.
  assign w_hq_next = {w_carry, w_sum, r_q[W-1:1]};
  assign w_last    = (r_cnt == CNT_W'(1));

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next state and status outputs
  always_comb begin
    w_state_next = r_state;
    busy         = 1'b0;
    done         = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) w_state_next = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (w_last) w_state_next = DONE;
      end
      DONE: begin
        busy         = 1'b1;
        done         = 1'b1;
        w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Datapath
  always_ff @(posedge clk) begin
    if (rst) begin
      r_m   <= '0;
      r_q   <= '0;
      r_h   <= '0;
      r_cnt <= '0;
      r_p   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_m   <= a;
            r_q   <= b;
            r_h   <= '0;
            r_cnt <= CNT_W'(W);
          end
        end
        RUN: begin
          {r_h, r_q} <= w_hq_next;
          r_cnt      <= r_cnt - CNT_W'(1);
          // p is loaded with the final step so it is valid on DONE entry.
          if (w_last) r_p <= w_hq_next;
        end
        default: ;
      endcase
    end
  end

  assign p = r_p;

`ifdef MULT_OVF_EN
  logic r_ovf;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ovf <= 1'b0;
    end else if (r_state == RUN && w_last) begin
      r_ovf <= |w_hq_next[2*W-1:W];
    end
  end

  assign ovf = r_ovf;
`endif

endmodule : shift_add_mult

// File: tb/tb_shift_add_mult.sv
// tb_shift_add_mult -- scoreboard bench for shift_add_mult (W=4).
// Stimulus pushes expected products; a negedge monitor pops on each done.
// Define MULT_OVF_EN to also check ovf.
module tb_shift_add_mult;

  localparam int W = 4;

  logic           clk;
  logic           rst;
  logic           start;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic           busy;
  logic           done;
  logic [2*W-1:0] p;
`ifdef MULT_OVF_EN
  logic           ovf;
`endif

  shift_add_mult #(.W(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .p     (p)
`ifdef MULT_OVF_EN
    ,
    .ovf   (ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2*W-1:0] p;
    logic           ovf;
    int             due;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   busy_run = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor / scoreboard
  always @(negedge clk) begin
    exp_t e;
    if (busy) busy_run++;
    if (done) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done: got done=1 at cycle %0d, required no done", cyc);
      end else begin
        e = q.pop_front();
        $display("txn: p=%h expected=%h cycle=%0d", p, e.p, cyc);
        if (p !== e.p) begin
          errors++;
          $display("FAIL product: got %h, required %h", p, e.p);
        end
        checks++;
        if (cyc != e.due) begin
          errors++;
          $display("FAIL latency: done at cycle %0d, required %0d", cyc, e.due);
        end
        checks++;
        if (busy_run != W + 1) begin
          errors++;
          $display("FAIL busy_len: got %0d cycles, required %0d", busy_run, W + 1);
        end
`ifdef MULT_OVF_EN
        checks++;
        if (ovf !== e.ovf) begin
          errors++;
          $display("FAIL ovf: got %b, required %b", ovf, e.ovf);
        end
`endif
      end
    end
    if (!busy) busy_run = 0;
  end

  // Issue one multiply, optionally disturbing start/a/b during RUN, and
  // wait (bounded) for its done pulse.
  task automatic mult(input logic [W-1:0] xa, input logic [W-1:0] xb,
                      input logic [2*W-1:0] exp_p, input bit noisy);
    exp_t e;
    int   n;
    @(negedge clk);
    a     = xa;
    b     = xb;
    start = 1'b1;
    e.p   = exp_p;
    e.ovf = |exp_p[2*W-1:W];
    e.due = cyc + W + 1;
    q.push_back(e);
    @(negedge clk);
    if (noisy) begin
      a = 4'h1;
      b = 4'h1;
      repeat (3) @(negedge clk);
    end else begin
      a     = ~xa;
      b     = ~xb;
      start = 1'b0;
    end
    start = 1'b0;
    n = 0;
    while (!done && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL timeout: no done for %h*%h, required done within 20 cycles", xa, xb);
    end
  endtask

  task automatic check_hold(input logic [2*W-1:0] exp_p);
    repeat (3) @(negedge clk);
    checks++;
    $display("txn: hold p=%h expected=%h", p, exp_p);
    if (p !== exp_p || busy !== 1'b0) begin
      errors++;
      $display("FAIL hold: got p=%h busy=%b, required p=%h busy=0", p, busy, exp_p);
    end
  endtask

  task automatic check_idle_zero(input string tag);
    checks++;
    $display("txn: %s busy=%b done=%b p=%h", tag, busy, done, p);
    if (busy !== 1'b0 || done !== 1'b0 || p !== '0) begin
      errors++;
      $display("FAIL %s: got busy=%b done=%b p=%h, required 0 0 00", tag, busy, done, p);
    end
`ifdef MULT_OVF_EN
    checks++;
    if (ovf !== 1'b0) begin
      errors++;
      $display("FAIL %s_ovf: got %b, required 0", tag, ovf);
    end
`endif
  endtask

  initial begin
    // Reset asserted together with start: reset must win.
    rst   = 1'b1;
    start = 1'b1;
    a     = 4'hF;
    b     = 4'hF;
    repeat (3) @(negedge clk);
    check_idle_zero("reset_state");
    rst   = 1'b0;
    start = 1'b0;
    repeat (2) @(negedge clk);

    // Directed vectors
    mult(4'h3, 4'h5, 8'h0F, 1'b0);
    check_hold(8'h0F);
    mult(4'hF, 4'hF, 8'hE1, 1'b0);
    check_hold(8'hE1);
    mult(4'h0, 4'hF, 8'h00, 1'b0);

    // start and operands changed during RUN are ignored
    mult(4'h7, 4'h6, 8'h2A, 1'b1);
    check_hold(8'h2A);

    // Reset in RUN cycle 2 aborts without a done pulse
    @(negedge clk);
    a     = 4'hD;
    b     = 4'hB;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_idle_zero("abort");
    repeat (8) @(negedge clk);
    mult(4'hD, 4'hB, 8'h8F, 1'b0);

    // Back-to-back: second start in the first IDLE cycle after DONE
    mult(4'h2, 4'h8, 8'h10, 1'b0);
    mult(4'h9, 4'h9, 8'h51, 1'b0);

    // Exhaustive sweep against the arithmetic product
    for (int i = 0; i < 16; i++) begin
      for (int j = 0; j < 16; j++) begin
        mult(i[3:0], j[3:0], 8'(i * j), 1'b0);
      end
    end

    repeat (5) @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL pending: got %0d outstanding products, required 0", q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_shift_add_mult

// File: doc/shift_add_mult.md
SHIFT_ADD_MULT -- requirements
Module: shift_add_mult

Interface
REQ-001 The block SHALL have parameter W, default 4, giving the operand width in bits; 2*W is the product width.
REQ-002 The block SHALL have port clk, input, 1 bit: the only clock, rising-edge active.
REQ-003 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port start, input, 1 bit: request to begin a multiply, sampled only in IDLE.
REQ-005 The block SHALL have port a, input, W bits: multiplicand, unsigned, captured on the accepted start.
REQ-006 The block SHALL have port b, input, W bits: multiplier, unsigned, captured on the accepted start.
REQ-007 The block SHALL have port busy, output, 1 bit: high whenever state is not IDLE.
REQ-008 The block SHALL have port done, output, 1 bit: one-cycle pulse when the product is valid.
REQ-009 The block SHALL have port p, output, 2*W bits: product, held from done until the next accepted start.
REQ-010 The block SHALL have port ovf, output, 1 bit, only when MULT_OVF_EN is defined: set when p[2W-1:W] is nonzero.

Function
REQ-011 The block SHALL implement an FSM with states IDLE, RUN and DONE.
REQ-012 In IDLE with start=1, the block SHALL load M<=a, Q<=b, H<=0, C<=0 and cnt<=W, then go to RUN.
REQ-013 Each RUN cycle SHALL compute {c,s}=H+(Q[0]?M:0) with a W-bit adder, then load {H,Q}<={c,s,Q[W-1:1]} and decrement cnt.
REQ-014 When cnt reaches 0 after a RUN step, the block SHALL go to DONE.
REQ-015 DONE SHALL last exactly one cycle with done=1 and p={H,Q}, then return to IDLE.
REQ-016 Latency SHALL be fixed: done is high in the cycle exactly W+1 clocks after the edge that samples start (5 clocks for W=4), independent of operand values.
REQ-017 start SHALL be ignored in RUN and DONE; it SHALL NOT restart, abort or alter the operation in progress.
REQ-018 a and b SHALL be don't-care after capture; changing them mid-RUN SHALL NOT affect the result.
REQ-019 p SHALL update only on entry to DONE and SHALL hold through IDLE until the next DONE.
REQ-020 Back-to-back use SHALL be supported: start high in the first IDLE cycle after DONE is accepted.
REQ-021 All arithmetic SHALL be unsigned; the adder carry-out SHALL be retained, so no product bits are lost (max (2^W-1)^2).

Reset
REQ-022 rst=1 at a clock edge SHALL force state IDLE, busy=0, done=0, p=0, cnt=0, M/Q/H=0 and, if MULT_OVF_EN is defined, ovf=0.
REQ-023 Reset SHALL take priority over start, including when both are high at the same edge.
REQ-024 Reset during RUN or DONE SHALL abort the operation; no done pulse SHALL be emitted for it.

Configuration
REQ-025 With macro MULT_OVF_EN defined, port ovf SHALL exist and SHALL update together with p (at DONE entry) and hold with it.
REQ-026 With MULT_OVF_EN undefined, port ovf and its register SHALL be absent; all other behaviour SHALL be identical.

Structure
REQ-027 Package mult_pkg SHALL hold the FSM state enum (IDLE, RUN, DONE) and the default width constant W_DEF=4.
REQ-028 The W-bit add SHALL be one sub-module, add_w: a ripple-carry adder with inputs x, y and cin=0, and outputs s and cout.
REQ-029 The counter SHALL be $clog2(W+1) bits wide.

Verification
REQ-030 A bench SHALL check: a=0x3, b=0x5, start pulse -> busy for 5 cycles, done pulse on cycle 5, p=0x0F, ovf=0.
REQ-031 A bench SHALL check: a=0xF, b=0xF -> p=0xE1, ovf=1; a=0x0, b=0xF -> p=0x00, with latency still 5 cycles.
REQ-032 A bench SHALL check: start re-asserted with a=0x1, b=0x1 during RUN of 0x7*0x6 -> single done, p=0x2A.
REQ-033 A bench SHALL check: rst in RUN cycle 2 -> next cycle busy=0, p=0, no done; a new start then yields a correct product.
REQ-034 A bench SHALL check: back-to-back 0x2*0x8 then 0x9*0x9 (start in the cycle after done) -> p=0x10 then p=0x51.
REQ-035 A bench SHALL run an exhaustive sweep of all 256 W=4 operand pairs against a reference model, with the macro both defined and undefined.
